// File: rtl/hqm_rcfwl_gclk_ccu_clkdist_mc.sv
// Multi-channel CCU clock distribution: ungated clock passthroughs plus per-channel ICG
// enables driven by independent four-phase req/ack ungate/gate FSMs with settle delays.
module hqm_rcfwl_gclk_ccu_clkdist_mc #(
  parameter int NUM_CH     = 4,
  parameter int UNGATE_DLY = 4,
  parameter int GATE_DLY   = 8,
  parameter int DIVW       = 4,
  parameter int ASYNC_REQ  = 0
) (
  input  logic              clkpredop_in,
  input  logic              rst_b,
  input  logic              fdft_slowmode,
  input  logic              fdft_clken,
  input  logic [DIVW-1:0]   slow_div,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_en,
  output logic              busy,
  output logic              ckpostdop_free,
  output logic              ascan_func_postclk
);

  typedef enum logic [1:0] {S_OFF, S_UNG, S_ON, S_GATE} state_t;

  // Counters load DLY-1 so the state changes exactly DLY edges after the triggering edge.
  localparam logic [7:0] UNG_LOAD  = (UNGATE_DLY == 0) ? 8'd0 : 8'(UNGATE_DLY - 1);
  localparam logic [7:0] GATE_LOAD = (GATE_DLY == 0) ? 8'd0 : 8'(GATE_DLY - 1);

  assign ckpostdop_free     = clkpredop_in;
  assign ascan_func_postclk = clkpredop_in;

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] wait_d;
  logic              busy_q;
  logic              pulse;
  logic [DIVW-1:0]   cnt_div_q, cnt_div_d;
  logic [DIVW-1:0]   div_lim_q, div_lim_d;

  generate
    if (ASYNC_REQ != 0) begin : g_sync
      logic [NUM_CH-1:0] sync1_q, sync2_q;
      always_ff @(posedge clkpredop_in or negedge rst_b) begin
        if (!rst_b) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= ch_req;
          sync2_q <= sync1_q;
        end
      end
      assign req_s = sync2_q;
    end else begin : g_nosync
      assign req_s = ch_req;
    end
  endgenerate

  // Slow-mode divider: the ratio is captured at the pulse cycle, so a change lands after the wrap.
  always_comb begin
    pulse     = !fdft_slowmode || (cnt_div_q == '0);
    cnt_div_d = '0;
    div_lim_d = div_lim_q;
    if (fdft_slowmode) begin
      if (cnt_div_q == '0) begin
        div_lim_d = slow_div;
        if (slow_div != '0) cnt_div_d = DIVW'(1);
      end else if (cnt_div_q != div_lim_q) begin
        cnt_div_d = cnt_div_q + DIVW'(1);
      end
    end
  end

  always_ff @(posedge clkpredop_in or negedge rst_b) begin
    if (!rst_b) begin
      cnt_div_q <= '0;
      div_lim_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_div_q <= cnt_div_d;
      div_lim_q <= div_lim_d;
      busy_q    <= |wait_d;
    end
  end

  assign busy = busy_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t     state_q, state_d;
      logic [7:0] cnt_q, cnt_d;
      logic       ack_d, run_d, wait_ch;
      logic       ack_q, en_q;

      always_ff @(posedge clkpredop_in or negedge rst_b) begin
        if (!rst_b) begin
          state_q <= S_OFF;
          cnt_q   <= '0;
          ack_q   <= 1'b0;
          en_q    <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          ack_q   <= ack_d;
          en_q    <= (run_d | fdft_clken) & pulse;
        end
      end

      // Requests are ignored while a wait is in progress; the handshake always completes.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          S_OFF: begin
            if (req_s[gi]) begin
              if (UNGATE_DLY == 0) begin
                state_d = S_ON;
              end else begin
                state_d = S_UNG;
                cnt_d   = UNG_LOAD;
              end
            end
          end
          S_UNG: begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else               state_d = S_ON;
          end
          S_ON: begin
            if (!req_s[gi]) begin
              if (GATE_DLY == 0) begin
                state_d = S_OFF;
              end else begin
                state_d = S_GATE;
                cnt_d   = GATE_LOAD;
              end
            end
          end
          S_GATE: begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else               state_d = S_OFF;
          end
          default: state_d = S_OFF;
        endcase
      end

      always_comb begin
        ack_d   = (state_d == S_ON) || (state_d == S_GATE);
        run_d   = (state_d == S_ON);
        wait_ch = (state_d == S_UNG) || (state_d == S_GATE);
      end

      assign wait_d[gi] = wait_ch;
      assign ch_ack[gi] = ack_q;
      assign ch_en[gi]  = en_q;
    end
  endgenerate

endmodule

// File: tb/tb_hqm_rcfwl_gclk_ccu_clkdist_mc.sv
// Bench for the multi-channel clock distribution block: handshake timing, slow mode,
// force-enable, protocol corner cases and randomized traffic against a timestamp model.
module tb_hqm_rcfwl_gclk_ccu_clkdist_mc;
  localparam int NCH = 4;
  localparam int UD  = 4;
  localparam int GD  = 8;
  localparam int DW  = 4;

  localparam int M_OFF  = 0;
  localparam int M_UNG  = 1;
  localparam int M_ON   = 2;
  localparam int M_GATE = 3;

  logic           clk = 1'b0;
  logic           rst_b = 1'b1;
  logic           slowmode = 1'b0;
  logic           clken = 1'b0;
  logic [DW-1:0]  sdiv = '0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] ack, en;
  logic           busy, free_clk, scan_clk;

  logic           slowmode2 = 1'b0;
  logic           clken2 = 1'b0;
  logic [DW-1:0]  sdiv2 = '0;
  logic [0:0]     req2 = '0;
  logic [0:0]     ack2, en2;
  logic           busy2, free2, scan2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Timestamp model: each channel remembers its phase and the edge at which that phase ends.
  int             mode [NCH];
  int             due  [NCH];
  int             slow_wait;
  int             edge_n;
  logic [NCH-1:0] m_ack, m_en;
  logic           m_busy;

  always #5 clk = ~clk;

  hqm_rcfwl_gclk_ccu_clkdist_mc #(
    .NUM_CH(NCH), .UNGATE_DLY(UD), .GATE_DLY(GD), .DIVW(DW), .ASYNC_REQ(0)
  ) dut (
    .clkpredop_in(clk), .rst_b(rst_b), .fdft_slowmode(slowmode), .fdft_clken(clken),
    .slow_div(sdiv), .ch_req(req), .ch_ack(ack), .ch_en(en), .busy(busy),
    .ckpostdop_free(free_clk), .ascan_func_postclk(scan_clk)
  );

  hqm_rcfwl_gclk_ccu_clkdist_mc #(
    .NUM_CH(1), .UNGATE_DLY(0), .GATE_DLY(0), .DIVW(DW), .ASYNC_REQ(1)
  ) dut_async (
    .clkpredop_in(clk), .rst_b(rst_b), .fdft_slowmode(slowmode2), .fdft_clken(clken2),
    .slow_div(sdiv2), .ch_req(req2), .ch_ack(ack2), .ch_en(en2), .busy(busy2),
    .ckpostdop_free(free2), .ascan_func_postclk(scan2)
  );

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_OFF;
      due[c]  = 0;
    end
    slow_wait = 0;
    m_ack     = '0;
    m_en      = '0;
    m_busy    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_edge();
    bit pulse;
    edge_n++;
    pulse  = !slowmode || (slow_wait == 0);
    m_busy = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      case (mode[c])
        M_OFF:  if (req[c]) begin
                  if (UD == 0) mode[c] = M_ON;
                  else begin mode[c] = M_UNG; due[c] = edge_n + UD; end
                end
        M_UNG:  if (edge_n == due[c]) mode[c] = M_ON;
        M_ON:   if (!req[c]) begin
                  if (GD == 0) mode[c] = M_OFF;
                  else begin mode[c] = M_GATE; due[c] = edge_n + GD; end
                end
        default: if (edge_n == due[c]) mode[c] = M_OFF;
      endcase
      m_ack[c] = (mode[c] == M_ON) || (mode[c] == M_GATE);
      m_en[c]  = ((mode[c] == M_ON) || clken) && pulse;
      if (mode[c] == M_UNG || mode[c] == M_GATE) m_busy = 1'b1;
    end
    // After each pulse, slow mode skips slow_div cycles (as seen at that pulse).
    if (!slowmode)            slow_wait = 0;
    else if (slow_wait == 0)  slow_wait = int'(sdiv);
    else                      slow_wait--;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 rst_b = 1'b0;
    #2;
    n_cmp++;
    if ({ack, en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: ack=%b en=%b busy=%b, expected all zero", ack, en, busy);
    end
    n_cmp++;
    if ({ack2, en2, busy2} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async2: ack=%b en=%b busy=%b, expected all zero", ack2, en2, busy2);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if ({free_clk, scan_clk, free2} !== 3'b111) begin
      n_fail++;
      $display("FAIL clk_pass_hi: free=%b scan=%b free2=%b, expected 111", free_clk, scan_clk, free2);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if ({free_clk, scan_clk, scan2} !== 3'b000) begin
      n_fail++;
      $display("FAIL clk_pass_lo: free=%b scan=%b scan2=%b, expected 000", free_clk, scan_clk, scan2);
    end
    rst_b = 1'b1;
    model_reset();
    edge_n = 0;
    tick();
    n_cmp++;
    if ({ack, en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: ack=%b en=%b busy=%b, expected all zero", ack, en, busy);
    end
  endtask

  task automatic test_handshake();
    req[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++;
      if ({ack[0], en[0], busy} !== {i >= 5, i >= 5, i <= 4}) begin
        n_fail++;
        $display("FAIL ungate_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=%b",
                 i, ack[0], en[0], busy, i >= 5, i >= 5, i <= 4);
      end
    end
    req[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if ({ack[0], en[0], busy} !== {i <= 8, 1'b0, i <= 8}) begin
        n_fail++;
        $display("FAIL gate_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=0 busy=%b",
                 i, ack[0], en[0], busy, i <= 8, i <= 8);
      end
    end
  endtask

  task automatic test_slowmode();
    req[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    slowmode = 1'b1;
    sdiv     = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if ({ack, en, busy} !== {m_ack, m_en, m_busy} || en[0] !== (i % 3 == 1)) begin
        n_fail++;
        $display("FAIL slow_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=%b (en0=%b)",
                 i, ack, en, busy, m_ack, m_en, m_busy, i % 3 == 1);
      end
    end
    sdiv = 4'd0;
    for (int i = 9; i <= 12; i++) begin
      tick();
      n_cmp++;
      if ({ack, en, busy} !== {m_ack, m_en, m_busy} || en[0] !== (i >= 10)) begin
        n_fail++;
        $display("FAIL slow_chg_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=%b (en0=%b)",
                 i, ack, en, busy, m_ack, m_en, m_busy, i >= 10);
      end
    end
    slowmode = 1'b0;
    req[0]   = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_force_clken();
    clken = 1'b1;
    tick();
    n_cmp++;
    if ({ack, en, busy} !== {4'b0000, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL force_on: ack=%b en=%b busy=%b, expected ack=0000 en=1111 busy=0", ack, en, busy);
    end
    clken = 1'b0;
    tick();
    n_cmp++;
    if ({ack, en, busy} !== '0) begin
      n_fail++;
      $display("FAIL force_off: ack=%b en=%b busy=%b, expected all zero", ack, en, busy);
    end
  endtask

  task automatic test_protocol();
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    for (int i = 2; i <= 22; i++) begin
      if (i == 8) req[1] = 1'b1;
      tick();
      n_cmp++;
      if ({ack, en, busy} !== {m_ack, m_en, m_busy}) begin
        n_fail++;
        $display("FAIL proto_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=%b",
                 i, ack, en, busy, m_ack, m_en, m_busy);
      end
    end
    n_cmp++;
    if (ack[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_reungate: ack1=%b, expected 1", ack[1]);
    end
    req[1] = 1'b0;
    tick();
    tick();
    #1 rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({ack, en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_midgate: ack=%b en=%b busy=%b, expected all zero", ack, en, busy);
    end
    @(posedge clk);
    #3 rst_b = 1'b1;
    model_reset();
    tick();
    n_cmp++;
    if ({ack, en, busy} !== '0) begin
      n_fail++;
      $display("FAIL after_reset: ack=%b en=%b busy=%b, expected all zero", ack, en, busy);
    end
  endtask

  task automatic test_async();
    req2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if ({ack2, en2, busy2} !== {i >= 3, i >= 3, 1'b0}) begin
        n_fail++;
        $display("FAIL async_up_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=0",
                 i, ack2, en2, busy2, i >= 3, i >= 3);
      end
    end
    req2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if ({ack2, en2, busy2} !== {i < 3, i < 3, 1'b0}) begin
        n_fail++;
        $display("FAIL async_dn_t%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=0",
                 i, ack2, en2, busy2, i < 3, i < 3);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) req[c] = ~req[c];
      if ($urandom_range(0, 59) == 0) slowmode = ~slowmode;
      if ($urandom_range(0, 39) == 0) clken = ~clken;
      sdiv = DW'($urandom_range(0, 3));
      tick();
      n_cmp++;
      if ({ack, en, busy} !== {m_ack, m_en, m_busy}) begin
        n_fail++;
        $display("FAIL rand_c%0d: ack=%b en=%b busy=%b, expected ack=%b en=%b busy=%b",
                 i, ack, en, busy, m_ack, m_en, m_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    edge_n = 0;
    test_reset();
    test_handshake();
    test_slowmode();
    test_force_clken();
    test_protocol();
    test_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
